// File: rtl/sseg_mux_driver.sv
// Time-multiplexed seven-segment driver for the board-level display.
// Scans latched hex nibbles across common-anode digits with PWM dimming.
module sseg_mux_driver #(
    parameter int DIGITS     = 4,
    parameter int CLK_HZ     = 65_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int BRIGHT_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   brightness,
    input  logic                  load,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int TICK_RAW = CLK_HZ / (REFRESH_HZ * DIGITS);
    localparam int TICK_DIV = (TICK_RAW < 2) ? 2 : TICK_RAW;
    localparam int PW       = $clog2(TICK_DIV);
    localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0] val_q;
    logic [DIGITS-1:0]   dp_q;
    logic [PW-1:0]       p;
    logic [IW-1:0]       idx;
    logic [BRIGHT_W-1:0] w;

    logic [DIGITS-1:0]   lz_mask;
    logic [3:0]          nib;
    logic                en_sel;
    logic                lz_sel;
    logic                dp_sel;
    logic                lit;
    logic [DIGITS-1:0]   an_nx;
    logic [6:0]          seg_nx;
    logic                dp_nx;

    function automatic logic [6:0] decode(input logic [3:0] h);
        logic [6:0] s;
        s = 7'h7F;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Shadow registers hold the displayed value between load strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
            dp_q  <= '0;
        end else if (load) begin
            val_q <= value;
            dp_q  <= dp_in;
        end
    end

    // Slot prescaler, digit index and free-running PWM counter
    always_ff @(posedge clk) begin
        if (rst) begin
            p   <= '0;
            idx <= '0;
            w   <= '0;
        end else begin
            w <= w + BRIGHT_W'(1);
            if (p == P_LAST) begin
                p   <= '0;
                idx <= (idx == I_LAST) ? '0 : idx + IW'(1);
            end else begin
                p <= p + PW'(1);
            end
        end
    end

    // Leading-zero mask: a digit blanks when it and all digits left of it are zero
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (val_q[4*k +: 4] == 4'h0);
            lz_mask[k] = blank_lz & zero_above & (k != 0);
        end
    end

    // Select the active digit's data and form the next pin values
    always_comb begin
        nib    = 4'h0;
        en_sel = 1'b0;
        lz_sel = 1'b0;
        dp_sel = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == idx) begin
                nib    = val_q[4*k +: 4];
                en_sel = digit_en[k];
                lz_sel = lz_mask[k];
                dp_sel = dp_q[k];
            end
        end
        // p==0 is the guard cycle that keeps anodes dark across the switch
        lit = (p != '0) & (w <= brightness) & en_sel & ~lz_sel;
        an_nx = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == idx) begin
                an_nx[k] = ~lit;
            end
        end
        seg_nx = lit ? decode(nib) : 7'h7F;
        dp_nx  = lit ? ~dp_sel : 1'b1;
    end

    // Registered pin drivers
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_nx;
            seg <= seg_nx;
            dp  <= dp_nx;
        end
    end

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Bench for sseg_mux_driver: cycle-count reference model plus
// directed scan, blanking, brightness, enable, reset and decode checks.
module tb_sseg_mux_driver;

    localparam int DIG = 4;
    localparam int TD  = 4;
    localparam int BW  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        blank_lz;
    logic [2:0]  brightness;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] dec_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    sseg_mux_driver #(
        .DIGITS(DIG), .CLK_HZ(4000), .REFRESH_HZ(250), .BRIGHT_W(BW)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in),
        .digit_en(digit_en), .blank_lz(blank_lz),
        .brightness(brightness), .load(load),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: everything follows from the cycle count since reset
    function automatic logic [11:0] model_out(
        input int c, input logic [15:0] v, input logic [3:0] dpv,
        input logic [3:0] en, input logic blz, input logic [2:0] br);
        int pp, d, wv;
        logic [3:0] nb;
        logic lzb, on;
        logic [3:0] a;
        logic [6:0] s;
        logic q;
        pp  = c % TD;
        d   = (c / TD) % DIG;
        wv  = c % (1 << BW);
        nb  = 4'(v >> (4 * d));
        lzb = blz && (d != 0) && ((v >> (4 * d)) == 16'h0);
        on  = (pp != 0) && (wv <= int'(br)) && en[d] && !lzb;
        a = 4'hF;
        s = 7'h7F;
        q = 1'b1;
        if (on) begin
            a[d] = 1'b0;
            s    = dec_tab[nb];
            q    = !dpv[d];
        end
        return {a, s, q};
    endfunction

    int          cyc = 0;
    logic [15:0] mval = '0;
    logic [3:0]  mdp = '0;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        mvalid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            e_an   <= 4'hF;
            e_seg  <= 7'h7F;
            e_dp   <= 1'b1;
            mval   <= '0;
            mdp    <= '0;
            cyc    <= 0;
            mvalid <= 1'b1;
        end else begin
            {e_an, e_seg, e_dp} <= model_out(cyc, mval, mdp, digit_en,
                                             blank_lz, brightness);
            if (load) begin
                mval <= value;
                mdp  <= dp_in;
            end
            cyc <= cyc + 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                check("an", an, e_an);
                check("seg", seg, e_seg);
                check("dp", dp, e_dp);
                check("an_onehot", ($countones(~an) <= 1), 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    logic [3:0] an_lit [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_lit [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    logic       dp_lit [4]  = '{1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int cnt [4];
        int low;
        bit found;
        logic [3:0] v4;

        rst = 1'b1; load = 1'b1; value = 16'hFFFF; dp_in = 4'hF;
        digit_en = 4'hF; blank_lz = 1'b0; brightness = 3'd7;

        // Reset held three cycles, load pulsed throughout
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_an", an, 4'hF);
            check("rst_seg", seg, 7'h7F);
            check("rst_dp", dp, 1'b1);
        end
        rst = 1'b0; load = 1'b0;
        @(negedge clk);
        check("rel_guard_an", an, 4'hF);
        @(negedge clk);
        check("rel_first_an", an, 4'b1110);
        check("rel_val_zero", seg, 7'b1000000);

        // Full-bright scan from a known phase
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; load = 1'b1; value = 16'h1234; dp_in = 4'b0100;
        @(negedge clk);
        load = 1'b0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if ((j + 1) % 4 == 0) begin
                check("scan_guard_an", an, 4'hF);
            end else begin
                check("scan_an", an, an_lit[(j + 1) / 4]);
                check("scan_seg", seg, seg_lit[(j + 1) / 4]);
                check("scan_dp", dp, dp_lit[(j + 1) / 4]);
            end
        end

        // Leading-zero blanking
        value = 16'h0070; load = 1'b1; blank_lz = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cnt = '{0, 0, 0, 0};
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) if (!an[k]) cnt[k]++;
            if (an == 4'b1101) check("lz_d1_seg", seg, 7'b1111000);
            if (an == 4'b1110) check("lz_d0_seg", seg, 7'b1000000);
        end
        check("lz_cnt0", cnt[0], 3);
        check("lz_cnt1", cnt[1], 3);
        check("lz_cnt2", cnt[2], 0);
        check("lz_cnt3", cnt[3], 0);
        value = 16'h0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cnt = '{0, 0, 0, 0};
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) if (!an[k]) cnt[k]++;
        end
        check("lz0_cnt0", cnt[0], 3);
        check("lz0_cnt123", cnt[1] + cnt[2] + cnt[3], 0);

        // Brightness: w and p share phase (w%4==p), so w==0 always
        // lands on the guard cycle and w==1 always lands on p==1
        blank_lz = 1'b0; value = 16'h1234; load = 1'b1; brightness = 3'd0;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        low = 0;
        for (int j = 0; j < 256; j++) begin
            @(negedge clk);
            if (an != 4'hF) low++;
        end
        check("bright0_low", low, 0);
        brightness = 3'd1;
        @(negedge clk);
        low = 0;
        for (int j = 0; j < 256; j++) begin
            @(negedge clk);
            if (an != 4'hF) low++;
        end
        check("bright1_low", low, 32);

        // Digit enable, then reset during digit 1's slot
        brightness = 3'd7; digit_en = 4'b1011;
        @(negedge clk);
        cnt = '{0, 0, 0, 0};
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) if (!an[k]) cnt[k]++;
        end
        check("en_cnt0", cnt[0], 3);
        check("en_cnt1", cnt[1], 3);
        check("en_cnt2", cnt[2], 0);
        check("en_cnt3", cnt[3], 3);
        found = 1'b0;
        for (int j = 0; j < 32 && !found; j++) begin
            @(negedge clk);
            if (an == 4'b1101) found = 1'b1;
        end
        check("wait_digit1", found, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_an", an, 4'hF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_dp", dp, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_guard", an, 4'hF);
        @(negedge clk);
        check("midrst_first", an, 4'b1110);
        check("midrst_seg0", seg, 7'b1000000);

        // Decode sweep, each nibble replicated into all digits
        digit_en = 4'hF;
        for (int v = 0; v < 16; v++) begin
            v4 = 4'(v);
            value = {v4, v4, v4, v4}; load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            found = 1'b0;
            for (int j = 0; j < 8 && !found; j++) begin
                @(negedge clk);
                if (an != 4'hF) found = 1'b1;
            end
            check("dec_lit", found, 1'b1);
            check("dec_seg", seg, dec_tab[v]);
        end

        // Randomised traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 299) == 0);
            load = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < 4; k++)
                value[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0
                                  : 4'($urandom_range(0, 15));
            dp_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0)
                digit_en = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 19) == 0) brightness = 3'($urandom);
        end
        rst = 1'b0; load = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
